// File: rtl/lsu_sequencer_pkg.sv
// Shared encodings for the load/store sequencer: load types, FSM states and
// the word-access classification used for alignment checking.
package lsu_sequencer_pkg;

    localparam logic [1:0] LT_LW  = 2'b00;
    localparam logic [1:0] LT_LB  = 2'b01;
    localparam logic [1:0] LT_LBU = 2'b10;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE     = 2'd0;
    localparam lsu_state_t ST_RAM_WAIT = 2'd1;
    localparam lsu_state_t ST_IO_WAIT  = 2'd2;

    // Stores are always full words; ltype 2'b11 behaves as lw.
    function automatic logic is_word_access(input logic is_store, input logic [1:0] lt);
        return is_store || !((lt == LT_LB) || (lt == LT_LBU));
    endfunction

endpackage

// File: rtl/lsu_sequencer_extract.sv
// Byte select and sign/zero extension of a 32-bit word, shared by the RAM
// and IO load return paths.
module load_extract
    import lsu_sequencer_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  ltype_i,
    output logic [31:0] data_o
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        case (ltype_i)
            LT_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  data_o = {24'h000000, byte_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_sequencer.sv
// MEM-stage sequencer: zero-penalty RAM stores, one-cycle RAM loads and
// handshaked IO accesses with a bounded wait, plus sticky error flags.
module lsu_sequencer
    import lsu_sequencer_pkg::*;
#(
    parameter int RAM_AW     = 14,
    parameter int IO_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              io_read,
    input  logic              io_write,
    input  logic [1:0]        ltype,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_req,
    output logic              io_we,
    output logic [7:0]        io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_ready,
    output logic              align_err,
    output logic              req_err,
    output logic              io_timeout
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(IO_TIMEOUT);

    lsu_state_t  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  lt_q, lt_d;
    logic        io_req_q, io_req_d;
    logic        io_we_q, io_we_d;
    logic [7:0]  io_addr_q, io_addr_d;
    logic [31:0] io_wdata_q, io_wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        align_q, align_d;
    logic        req_err_q, req_err_d;
    logic        tmo_q, tmo_d;

    logic [2:0]  req_cnt;
    logic [31:0] ext_word;
    logic [31:0] ext_data;
    logic        unused_addr_hi;

    assign req_cnt = {2'b00, mem_read} + {2'b00, mem_write} + {2'b00, io_read} + {2'b00, io_write};
    assign unused_addr_hi = ^addr[31:RAM_AW+2];

    load_extract u_extract (
        .word_i   (ext_word),
        .offset_i (off_q),
        .ltype_i  (lt_q),
        .data_o   (ext_data)
    );

    // Combinational strobes are forced low while reset is held so that a
    // request sitting on the inputs cannot leak out during reset.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        lt_d        = lt_q;
        io_req_d    = io_req_q;
        io_we_d     = io_we_q;
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        cnt_d       = cnt_q;
        align_d     = align_q;
        req_err_d   = req_err_q;
        tmo_d       = tmo_q;
        stall       = 1'b0;
        rdata       = 32'h0;
        rdata_valid = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = 32'h0;
        ext_word    = io_rdata;

        if (rst_n) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_cnt > 3'd1) begin
                        req_err_d = 1'b1;
                    end else if (req_cnt == 3'd1) begin
                        if (is_word_access(mem_write | io_write, ltype) && (addr[1:0] != 2'b00))
                            align_d = 1'b1;
                        off_d = addr[1:0];
                        lt_d  = ltype;
                        if (mem_read || mem_write) begin
                            ram_en    = 1'b1;
                            ram_we    = mem_write;
                            ram_addr  = addr[RAM_AW+1:2];
                            ram_wdata = mem_write ? wdata : 32'h0;
                        end
                        if (mem_read) begin
                            stall   = 1'b1;
                            state_d = ST_RAM_WAIT;
                        end
                        if (io_read || io_write) begin
                            io_req_d   = 1'b1;
                            io_we_d    = io_write;
                            io_addr_d  = addr[7:0];
                            io_wdata_d = wdata;
                            cnt_d      = 8'h00;
                            stall      = 1'b1;
                            state_d    = ST_IO_WAIT;
                        end
                    end
                end
                ST_RAM_WAIT: begin
                    ext_word    = ram_rdata;
                    rdata       = ext_data;
                    rdata_valid = 1'b1;
                    state_d     = ST_IDLE;
                end
                ST_IO_WAIT: begin
                    // A ready arriving on the timeout cycle still wins.
                    if (io_ready || (cnt_q == TIMEOUT_LIM)) begin
                        io_req_d = 1'b0;
                        io_we_d  = 1'b0;
                        state_d  = ST_IDLE;
                        if (!io_ready)
                            tmo_d = 1'b1;
                        if (!io_we_q) begin
                            rdata_valid = 1'b1;
                            rdata       = io_ready ? ext_data : 32'h0;
                        end
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + 8'h01;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            off_q      <= 2'b00;
            lt_q       <= LT_LW;
            io_req_q   <= 1'b0;
            io_we_q    <= 1'b0;
            io_addr_q  <= 8'h00;
            io_wdata_q <= 32'h0;
            cnt_q      <= 8'h00;
            align_q    <= 1'b0;
            req_err_q  <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            lt_q       <= lt_d;
            io_req_q   <= io_req_d;
            io_we_q    <= io_we_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
            cnt_q      <= cnt_d;
            align_q    <= align_d;
            req_err_q  <= req_err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign io_req     = io_req_q;
    assign io_we      = io_we_q;
    assign io_addr    = io_addr_q;
    assign io_wdata   = io_wdata_q;
    assign align_err  = align_q;
    assign req_err    = req_err_q;
    assign io_timeout = tmo_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Randomized scoreboard bench for lsu_sequencer: expected load results are
// queued at issue time from a word-array memory model and popped by a monitor.
module tb_lsu_sequencer;

    localparam int RAM_AW     = 8;
    localparam int IO_TIMEOUT = 4;
    localparam int RAM_WORDS  = 1 << RAM_AW;

    logic              clk;
    logic              rst_n;
    logic              mem_read, mem_write, io_read, io_write;
    logic [1:0]        ltype;
    logic [31:0]       addr, wdata;
    logic              stall;
    logic [31:0]       rdata;
    logic              rdata_valid;
    logic              ram_en, ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;
    logic              io_req, io_we;
    logic [7:0]        io_addr;
    logic [31:0]       io_wdata, io_rdata;
    logic              io_ready;
    logic              align_err, req_err, io_timeout;

    int checks = 0;
    int errors = 0;

    logic [31:0] refMem [RAM_WORDS];
    logic [31:0] ramArr [RAM_WORDS];
    bit          ramReady = 1'b0;
    logic [31:0] expQ [$];
    bit          expAlign, expReq, expTimeout;

    lsu_sequencer #(.RAM_AW(RAM_AW), .IO_TIMEOUT(IO_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .io_read(io_read), .io_write(io_write),
        .ltype(ltype), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ready(io_ready),
        .align_err(align_err), .req_err(req_err), .io_timeout(io_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // Little-endian byte pick by shifting, then sign or zero extension.
    function automatic logic [31:0] refExtract(input logic [31:0] w, input logic [1:0] off, input logic [1:0] lt);
        logic [7:0] b;
        b = 8'(w >> (8 * int'(off)));
        if (lt == 2'b01) return {{24{b[7]}}, b};
        if (lt == 2'b10) return {24'h0, b};
        return w;
    endfunction

    // Synchronous single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (!ramReady) begin
            for (int i = 0; i < RAM_WORDS; i++) ramArr[i] <= initWord(i);
            ramReady <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) ramArr[ram_addr] <= ram_wdata;
            else        ram_rdata <= ramArr[ram_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rdata_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rdata_valid_unexpected at %0t: got 1 expected 0", $time);
            end else begin
                checkOutput("rdata", rdata, expQ.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, "_align_err"}, align_err, expAlign);
        checkOutput({tag, "_req_err"}, req_err, expReq);
        checkOutput({tag, "_io_timeout"}, io_timeout, expTimeout);
    endtask

    task automatic applyStore(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1; addr = a; wdata = d; ltype = 2'(($urandom));
        @(negedge clk);
        checkOutput("store_stall", stall, 0);
        checkOutput("store_ram_en", ram_en, 1);
        checkOutput("store_ram_we", ram_we, 1);
        checkOutput("store_ram_addr", ram_addr, a[RAM_AW+1:2]);
        checkOutput("store_ram_wdata", ram_wdata, d);
        refMem[a[RAM_AW+1:2]] = d;
        if (a[1:0] != 2'b00) expAlign = 1'b1;
        tick();
        mem_write = 1'b0;
        checkFlags("store");
    endtask

    task automatic applyLoad(input logic [31:0] a, input logic [1:0] lt);
        mem_read = 1'b1; addr = a; ltype = lt;
        expQ.push_back(refExtract(refMem[a[RAM_AW+1:2]], a[1:0], lt));
        if ((lt == 2'b00 || lt == 2'b11) && a[1:0] != 2'b00) expAlign = 1'b1;
        @(negedge clk);
        checkOutput("load_issue_stall", stall, 1);
        checkOutput("load_ram_en", ram_en, 1);
        checkOutput("load_ram_we", ram_we, 0);
        checkOutput("load_ram_addr", ram_addr, a[RAM_AW+1:2]);
        tick();
        mem_read = 1'b0; addr = $urandom; ltype = 2'($urandom);
        @(negedge clk);
        checkOutput("load_wait_stall", stall, 0);
        tick();
        checkFlags("load");
    endtask

    // delay = IO_WAIT cycle index at which io_ready is raised; beyond IO_TIMEOUT means never.
    task automatic applyIo(input bit isWrite, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int delay, input logic [1:0] lt);
        bit done;
        io_read = !isWrite; io_write = isWrite; addr = a; wdata = wd; ltype = lt;
        if (!isWrite) expQ.push_back((delay <= IO_TIMEOUT) ? refExtract(rd, a[1:0], lt) : 32'h0);
        if ((isWrite || lt == 2'b00 || lt == 2'b11) && a[1:0] != 2'b00) expAlign = 1'b1;
        @(negedge clk);
        checkOutput("io_issue_stall", stall, 1);
        checkOutput("io_issue_ram_en", ram_en, 0);
        tick();
        io_read = 1'b0; io_write = 1'b0; addr = $urandom; wdata = $urandom; ltype = 2'($urandom);
        done = 1'b0;
        for (int k = 0; k <= IO_TIMEOUT && !done; k++) begin
            io_ready  = (k == delay);
            io_rdata  = (k == delay) ? rd : $urandom;
            mem_write = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("io_wait_req", io_req, 1);
            checkOutput("io_wait_we", io_we, isWrite);
            checkOutput("io_wait_addr", io_addr, a[7:0]);
            checkOutput("io_wait_wdata", io_wdata, wd);
            checkOutput("io_wait_ram_en", ram_en, 0);
            if (k == delay || k == IO_TIMEOUT) begin
                checkOutput("io_done_stall", stall, 0);
                if (k != delay) expTimeout = 1'b1;
                done = 1'b1;
            end else begin
                checkOutput("io_wait_stall", stall, 1);
            end
            tick();
        end
        io_ready = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        checkOutput("io_after_req", io_req, 0);
        checkOutput("io_after_stall", stall, 0);
        tick();
        checkFlags("io");
    endtask

    task automatic applyMulti(input logic [3:0] req);
        {mem_read, mem_write, io_read, io_write} = req;
        addr = $urandom; wdata = $urandom; ltype = 2'($urandom);
        @(negedge clk);
        checkOutput("multi_stall", stall, 0);
        checkOutput("multi_ram_en", ram_en, 0);
        tick();
        {mem_read, mem_write, io_read, io_write} = 4'b0000;
        expReq = 1'b1;
        checkOutput("multi_io_req", io_req, 0);
        checkFlags("multi");
    endtask

    task automatic applyIoReset(input logic [31:0] a);
        io_read = 1'b1; addr = a; ltype = 2'b00;
        @(negedge clk);
        checkOutput("rst_io_issue_stall", stall, 1);
        tick();
        io_read = 1'b0; io_ready = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        expAlign = 1'b0; expReq = 1'b0; expTimeout = 1'b0;
        checkOutput("rst_io_req", io_req, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_rdata_valid", rdata_valid, 0);
        checkFlags("rst");
        @(negedge clk);
        checkOutput("rst_hold_rdata_valid", rdata_valid, 0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] mreq;
        int op;
        rst_n = 1'b0;
        {mem_read, mem_write, io_read, io_write} = 4'b0000;
        ltype = 2'b00; addr = 32'h0; wdata = 32'h0; io_rdata = 32'h0; io_ready = 1'b0;
        expAlign = 1'b0; expReq = 1'b0; expTimeout = 1'b0;
        for (int i = 0; i < RAM_WORDS; i++) refMem[i] = initWord(i);

        mem_read = 1'b1; addr = 32'h13;
        #2;
        checkOutput("reset_stall", stall, 0);
        checkOutput("reset_ram_en", ram_en, 0);
        checkOutput("reset_ram_addr", ram_addr, 0);
        checkOutput("reset_rdata_valid", rdata_valid, 0);
        checkOutput("reset_rdata", rdata, 0);
        checkOutput("reset_io_req", io_req, 0);
        checkOutput("reset_io_wdata", io_wdata, 0);
        checkFlags("reset");
        mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        applyStore(32'h20, 32'hDEAD_BEEF);
        applyLoad(32'h20, 2'b00);
        applyStore(32'h10, 32'h8081_82F3);
        applyLoad(32'h10, 2'b01);
        applyLoad(32'h11, 2'b10);
        applyIo(1'b0, 32'h40, 32'h0, 32'h5A, 3, 2'b00);
        applyIo(1'b0, 32'h48, 32'h77, 32'h0000_00C3, IO_TIMEOUT, 2'b01);
        applyIo(1'b1, 32'h44, 32'h1234_5678, 32'h0, 255, 2'b00);
        applyMulti(4'b1010);
        applyLoad(32'h3, 2'b00);
        applyIoReset(32'h50);
        applyLoad(32'h20, 2'b00);
        applyIo(1'b0, 32'h52, 32'h0, 32'hA5B6_C7D8, 0, 2'b10);

        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1:    applyStore($urandom, $urandom);
                2, 3, 4: applyLoad($urandom, 2'($urandom));
                5, 6:    applyIo(1'b0, $urandom, $urandom, $urandom, $urandom_range(0, 6), 2'($urandom));
                7, 8:    applyIo(1'b1, $urandom, $urandom, $urandom, $urandom_range(0, 6), 2'($urandom));
                default: begin
                    do mreq = 4'($urandom); while ($countones(mreq) < 2);
                    applyMulti(mreq);
                end
            endcase
        end

        repeat (3) tick();
        checkOutput("scoreboard_drain", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
